axi4_master: RTL

Single-outstanding AXI4 initiator that converts a simple command/response interface into transactions on the write-address, write-data, write-response, read-address and read-data channels. It is the counterpart of the team's `axi4_slave` and shares its channel subset: 32-bit address and data, no IDs, bursts, strobes or resp codes. A per-phase handshake timeout turns a hung slave into an error response instead of a deadlock.

---
 rtl/axi4_master.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/axi4_master.sv
// axi4_master: single-outstanding AXI4 initiator bridging a command/response port to AW/W/B/AR/R channels.
// Ports: clk, reset_n (async, active-low)
//   command   : cmd_valid, cmd_ready, cmd_write, cmd_addr[31:0], cmd_wdata[31:0]
//   response  : rsp_valid (1-cycle pulse), rsp_rdata[31:0], rsp_err (timeout abort), busy
//   AXI write : awaddr/awvalid/awready, wdata/wvalid/wready, bvalid/bready
//   AXI read  : araddr/arvalid/arready, rdata/rvalid/rready
// TIMEOUT: cycles allowed per wait phase (0 disables, max 65535).
module axi4_master #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready
);
    typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R} state_t;
    state_t state, state_d;
    logic [15:0] cnt, cnt_d;
    logic [31:0] awaddr_d, wdata_d, araddr_d, rsp_rdata_d;
    logic awvalid_d, wvalid_d, arvalid_d, bready_d, rready_d, rsp_valid_d, rsp_err_d;
    logic expire, abort;
    // expiry fires on the edge where the held-state count would reach TIMEOUT
    assign expire = (TIMEOUT != 0) && (({1'b0, cnt} + 17'd1) == 17'(TIMEOUT));
    always_comb begin
        state_d     = state;
        awaddr_d    = awaddr;
        wdata_d     = wdata;
        araddr_d    = araddr;
        awvalid_d   = awvalid;
        wvalid_d    = wvalid;
        arvalid_d   = arvalid;
        bready_d    = bready;
        rready_d    = rready;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'd0;
        abort       = 1'b0;
        unique case (state)
            IDLE: if (cmd_valid && cmd_ready) begin
                if (cmd_write) begin
                    awaddr_d  = cmd_addr;
                    wdata_d   = cmd_wdata;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = WR_AW_W;
                end else begin
                    araddr_d  = cmd_addr;
                    arvalid_d = 1'b1;
                    state_d   = RD_AR;
                end
            end
            WR_AW_W: begin
                if (awvalid && awready) awvalid_d = 1'b0;
                if (wvalid && wready) wvalid_d = 1'b0;
                if ((!awvalid || awready) && (!wvalid || wready)) begin
                    bready_d = 1'b1;
                    state_d  = WR_B;
                end else abort = expire;
            end
            WR_B: if (bvalid && bready) begin
                bready_d    = 1'b0;
                rsp_valid_d = 1'b1;
                state_d     = IDLE;
            end else abort = expire;
            RD_AR: if (arvalid && arready) begin
                arvalid_d = 1'b0;
                rready_d  = 1'b1;
                state_d   = RD_R;
            end else abort = expire;
            RD_R: if (rvalid && rready) begin
                rready_d    = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = rdata;
                state_d     = IDLE;
            end else abort = expire;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            arvalid_d   = 1'b0;
            bready_d    = 1'b0;
            rready_d    = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            state_d     = IDLE;
        end
        cnt_d = (state_d == state && state != IDLE) ? cnt + 16'd1 : 16'd0;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= 16'd0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
            awaddr    <= 32'd0;
            wdata     <= 32'd0;
            araddr    <= 32'd0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            arvalid   <= 1'b0;
            bready    <= 1'b0;
            rready    <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            cmd_ready <= state_d == IDLE;
            busy      <= state_d != IDLE;
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            rsp_rdata <= rsp_rdata_d;
            awaddr    <= awaddr_d;
            wdata     <= wdata_d;
            araddr    <= araddr_d;
            awvalid   <= awvalid_d;
            wvalid    <= wvalid_d;
            arvalid   <= arvalid_d;
            bready    <= bready_d;
            rready    <= rready_d;
        end
    end
endmodule
